// File: rtl/barrel_feeder_if.sv
// -----------------------------------------------------------------------------
// barrel_feeder_if
// Bundles the command, shifter and result signals of barrel_feeder.
//
// Signal summary:
//   cmd_valid / cmd_ready / cmd_data[7:0] / cmd_sel[2:0]   command intake
//   sh_load / sh_sel[2:0] / sh_data[7:0] / sh_result[7:0]  external shifter
//   res_valid / res_ready / res_data[7:0]                  result delivery
//   level[4:0]                                             FIFO occupancy
//   err / err_cnt[7:0]                                     self-check status
//
// Modports:
//   slave  - the barrel_feeder itself
//   master - the environment (upstream, shifter and consumer)
// -----------------------------------------------------------------------------
interface barrel_feeder_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_sel;
    logic       sh_load;
    logic [2:0] sh_sel;
    logic [7:0] sh_data;
    logic [7:0] sh_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [4:0] level;
    logic       err;
    logic [7:0] err_cnt;

    modport slave (
        input  cmd_valid, cmd_data, cmd_sel, sh_result, res_ready,
        output cmd_ready, sh_load, sh_sel, sh_data, res_valid, res_data,
               level, err, err_cnt
    );

    modport master (
        output cmd_valid, cmd_data, cmd_sel, sh_result, res_ready,
        input  cmd_ready, sh_load, sh_sel, sh_data, res_valid, res_data,
               level, err, err_cnt
    );
endinterface : barrel_feeder_if

// File: rtl/barrel_feeder.sv
// -----------------------------------------------------------------------------
// barrel_feeder
// Queues {sel, data} rotate commands in a small FIFO, issues them one at a time
// to an external barrel shifter (sh_load strobe), waits LAT cycles, captures the
// shifter result and presents it on a valid/ready result port. Results leave in
// command order.
//
// Parameters:
//   DEPTH - command FIFO entries (power of 2, 2..16)
//   LAT   - cycles from sh_load high to sh_result valid (1..7)
//
// Ports:
//   clk   - sole clock, rising edge
//   reset - synchronous active-low reset
//   bus   - barrel_feeder_if.slave (command, shifter, result, status signals)
//
// Optional build macro:
//   BARREL_FEEDER_CHECK_EN - when defined, every captured sh_result is compared
//   against the expected rotate-left of sh_data by sh_sel; mismatches set the
//   sticky err flag and bump the saturating err_cnt. When undefined, err and
//   err_cnt are tied to zero and no compare logic exists.
// -----------------------------------------------------------------------------
module barrel_feeder #(
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input logic             clk,
    input logic             reset,
    barrel_feeder_if.slave  bus
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_L = 5'(DEPTH);
    localparam logic [2:0] LAT_L   = 3'(LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [10:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    level_q, level_d;

    // Sequencer state and registered outputs
    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          sh_load_q, sh_load_d;
    logic [7:0]    sh_data_q, sh_data_d;
    logic [2:0]    sh_sel_q, sh_sel_d;
    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_data_q, res_data_d;

    // Combinational helpers
    logic          cmd_ready_s;
    logic          push_s;
    logic          pop_s;
    logic          capture_s;
    logic          fifo_ne_s;
    logic [7:0]    head_data_s;
    logic [2:0]    head_sel_s;

    // FIFO status and head decode; ready comes only from the registered level,
    // so a full FIFO never accepts even if a pop happens on the same edge.
    always_comb begin
        cmd_ready_s = (level_q != DEPTH_L);
        push_s      = bus.cmd_valid && cmd_ready_s;
        fifo_ne_s   = (level_q != 5'd0);
        head_data_s = mem_q[rd_ptr_q][7:0];
        head_sel_s  = mem_q[rd_ptr_q][10:8];
    end

    // FIFO pointer and occupancy next-state; pointers wrap naturally modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        level_d = level_q + {4'd0, push_s} - {4'd0, pop_s};
    end

    // FIFO storage write; contents need no reset because the pointers flush it.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.cmd_sel, bus.cmd_data};
        end
    end

    // Sequencer next-state and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_load_d   = 1'b0;
        sh_data_d   = sh_data_q;
        sh_sel_d    = sh_sel_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        pop_s       = 1'b0;
        capture_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fifo_ne_s) begin
                    pop_s     = 1'b1;
                    sh_load_d = 1'b1;
                    sh_data_d = head_data_s;
                    sh_sel_d  = head_sel_s;
                    cnt_d     = 3'd0;
                    state_d   = S_WAIT;
                end else begin
                    state_d   = S_IDLE;
                end
            end

            // cnt starts at 0 in the sh_load cycle; the edge that sees cnt == LAT
            // is the first one where the shifter output is guaranteed valid.
            S_WAIT: begin
                if (cnt_q == LAT_L) begin
                    capture_s   = 1'b1;
                    res_data_d  = bus.sh_result;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    cnt_d       = cnt_q + 3'd1;
                end
            end

            // On the handshake edge the next queued command is issued directly,
            // which keeps back-to-back sh_load pulses LAT+2 cycles apart.
            S_HOLD: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    if (fifo_ne_s) begin
                        pop_s     = 1'b1;
                        sh_load_d = 1'b1;
                        sh_data_d = head_data_s;
                        sh_sel_d  = head_sel_s;
                        cnt_d     = 3'd0;
                        state_d   = S_WAIT;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end

            default: begin
                state_d     = S_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer, FIFO bookkeeping and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= 5'd0;
            sh_load_q   <= 1'b0;
            sh_data_q   <= 8'd0;
            sh_sel_q    <= 3'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            sh_load_q   <= sh_load_d;
            sh_data_q   <= sh_data_d;
            sh_sel_q    <= sh_sel_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

`ifdef BARREL_FEEDER_CHECK_EN
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // Reference rotate-left of one byte; sel = 0 returns the byte unchanged.
    function automatic logic [7:0] rotl8(input logic [7:0] d, input logic [2:0] s);
        logic [15:0] dbl;
        dbl = {d, d} << s;
        return dbl[15:8];
    endfunction

    // Compare the captured shifter result with the expected rotation.
    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (capture_s && (bus.sh_result != rotl8(sh_data_q, sh_sel_q))) begin
            err_d = 1'b1;
            if (err_cnt_q == 8'hFF) begin
                err_cnt_d = 8'hFF;
            end else begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end else begin
            err_d     = err_q;
            err_cnt_d = err_cnt_q;
        end
    end

    // Sticky error flag and saturating mismatch counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err     = 1'b0;
    assign bus.err_cnt = 8'd0;
`endif

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.sh_load   = sh_load_q;
    assign bus.sh_data   = sh_data_q;
    assign bus.sh_sel    = sh_sel_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.level     = level_q;

endmodule : barrel_feeder

// File: tb/tb_barrel_feeder.sv
// -----------------------------------------------------------------------------
// tb_barrel_feeder
// Self-checking bench for barrel_feeder (default DEPTH = 4, LAT = 1). Contains a
// registered one-cycle shifter model, a rotation vector table, hand-written
// timing sequences and a randomized run checked against an in-order queue.
// -----------------------------------------------------------------------------
module tb_barrel_feeder;

    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic corrupt = 1'b0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    bit   rnd_mon = 1'b0;
    int   load_cyc[$];
    logic [7:0] exp_q[$];

    barrel_feeder_if bus();

    barrel_feeder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Rotate-left computed with plain integer arithmetic.
    function automatic logic [7:0] rotl_ref(input logic [7:0] d, input logic [2:0] s);
        int v;
        v = (int'(d) << int'(s)) | (int'(d) >> (8 - int'(s)));
        return v[7:0];
    endfunction

    // Downstream shifter: result valid one cycle after the load.
    always @(posedge clk) begin
        bus.sh_result <= corrupt ? 8'h00 : rotl_ref(bus.sh_data, bus.sh_sel);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Record load cycles; during the random run also score results and pushes.
    always @(negedge clk) begin
        if (bus.sh_load === 1'b1) load_cyc.push_back(cyc);
        if (rnd_mon && reset) begin
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) check("rnd_unexpected_result", 32'd1, 32'd0);
                else check("rnd_result", 32'(bus.res_data), 32'(exp_q.pop_front()));
            end
            if (bus.cmd_valid && bus.cmd_ready) exp_q.push_back(rotl_ref(bus.cmd_data, bus.cmd_sel));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_sel   = s;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for res_valid; caller keeps res_ready high to consume it.
    task automatic wait_res(input string name, output logic [7:0] d);
        bit ok = 1'b0;
        d = 8'h00;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            if (bus.res_valid) begin
                ok = 1'b1;
                d  = bus.res_data;
            end
        end
        check({name, "_timeout"}, 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [7:0] r;
        int         acc;
        logic [7:0] exp39[$];
        bit         seen;

        vecs[0] = '{8'h81, 3'd1, 8'h03};
        vecs[1] = '{8'hA5, 3'd0, 8'hA5};
        vecs[2] = '{8'h96, 3'd4, 8'h69};
        vecs[3] = '{8'h01, 3'd7, 8'h80};
        vecs[4] = '{8'h80, 3'd1, 8'h01};
        vecs[5] = '{8'hF0, 3'd2, 8'hC3};
        vecs[6] = '{8'h12, 3'd3, 8'h90};
        vecs[7] = '{8'hFF, 3'd5, 8'hFF};
        vecs[8] = '{8'h3C, 3'd6, 8'h0F};
        vecs[9] = '{8'hB7, 3'd7, 8'hDB};

        reset = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.cmd_sel   = 3'd0;
        bus.res_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_sh_load", 32'(bus.sh_load), 32'd0);
        check("rst_sh_data", 32'(bus.sh_data), 32'd0);
        check("rst_sh_sel", 32'(bus.sh_sel), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        reset = 1'b1;
        tick();

        // Single command timing: 0x81 sel 1
        push(8'h81, 3'd1);
        check("t37_level_after_push", 32'(bus.level), 32'd1);
        check("t37_no_load_yet", 32'(bus.sh_load), 32'd0);
        tick();
        check("t37_sh_load", 32'(bus.sh_load), 32'd1);
        check("t37_sh_data", 32'(bus.sh_data), 32'h81);
        check("t37_sh_sel", 32'(bus.sh_sel), 32'd1);
        check("t37_level_popped", 32'(bus.level), 32'd0);
        tick();
        check("t37_load_pulse_end", 32'(bus.sh_load), 32'd0);
        check("t37_not_valid_early", 32'(bus.res_valid), 32'd0);
        tick();
        check("t37_res_valid", 32'(bus.res_valid), 32'd1);
        check("t37_res_data", 32'(bus.res_data), 32'h03);
        tick();
        check("t37_res_cleared", 32'(bus.res_valid), 32'd0);
        repeat (2) tick();

        // Table of rotations, one command at a time
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].d, vecs[i].s);
            wait_res("tbl", r);
            check($sformatf("tbl_%0d", i), 32'(r), 32'(vecs[i].exp));
        end
        repeat (3) tick();

        // Ordered pair and load spacing
        load_cyc.delete();
        push(8'hA5, 3'd0);
        push(8'h96, 3'd4);
        wait_res("t38_a", r);
        check("t38_first", 32'(r), 32'hA5);
        wait_res("t38_b", r);
        check("t38_second", 32'(r), 32'h69);
        check("t38_load_count", 32'(load_cyc.size()), 32'd2);
        if (load_cyc.size() == 2)
            check("t38_load_spacing", 32'(load_cyc[1] - load_cyc[0]), 32'(LAT + 2));
        repeat (3) tick();

        // Back-pressure: six back-to-back offers with res_ready low
        bus.res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = 8'(8'h11 * (i + 1));
            bus.cmd_sel   = 3'(i + 1);
            if (bus.cmd_ready) begin
                acc++;
                exp39.push_back(rotl_ref(bus.cmd_data, bus.cmd_sel));
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("t39_accepted", 32'(acc), 32'd5);
        check("t39_level_full", 32'(bus.level), 32'd4);
        check("t39_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
        check("t39_holding", 32'(bus.res_valid), 32'd1);
        bus.res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) r = bus.res_data;
            else wait_res("t39", r);
            check($sformatf("t39_result_%0d", i), 32'(r), 32'(exp39.size() > 0 ? exp39.pop_front() : 8'h00));
        end
        repeat (3) tick();

        // Reset while a command is in flight
        push(8'h5A, 3'd2);
        push(8'h77, 3'd3);
        check("t40_in_wait", 32'(bus.sh_load), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t40_level", 32'(bus.level), 32'd0);
        check("t40_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("t40_res_valid", 32'(bus.res_valid), 32'd0);
        check("t40_sh_load", 32'(bus.sh_load), 32'd0);
        check("t40_sh_data", 32'(bus.sh_data), 32'd0);
        check("t40_res_data", 32'(bus.res_data), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.res_valid || bus.sh_load) seen = 1'b1;
        end
        check("t40_no_ghost_result", 32'(seen), 32'd0);
        push(8'h0F, 3'd4);
        wait_res("t40_after", r);
        check("t40_after_reset", 32'(r), 32'hF0);
        repeat (3) tick();

        // Self-check: corrupted shifter result, then a good one
        corrupt = 1'b1;
        push(8'h81, 3'd1);
        wait_res("t41_bad", r);
        corrupt = 1'b0;
        check("t41_bad_data", 32'(r), 32'h00);
`ifdef BARREL_FEEDER_CHECK_EN
        check("t41_err_set", 32'(bus.err), 32'd1);
        check("t41_err_cnt", 32'(bus.err_cnt), 32'd1);
`else
        check("t41_err_off", 32'(bus.err), 32'd0);
        check("t41_err_cnt_off", 32'(bus.err_cnt), 32'd0);
`endif
        repeat (2) tick();
        push(8'h81, 3'd1);
        wait_res("t41_good", r);
        check("t41_good_data", 32'(r), 32'h03);
`ifdef BARREL_FEEDER_CHECK_EN
        check("t41_err_sticky", 32'(bus.err), 32'd1);
        check("t41_err_cnt_hold", 32'(bus.err_cnt), 32'd1);
`else
        check("t41_err_still_off", 32'(bus.err), 32'd0);
`endif
        repeat (3) tick();

        // Randomized traffic against the in-order queue model
        exp_q.delete();
        rnd_mon = 1'b1;
        for (int i = 0; i < 600; i++) begin
            bus.cmd_valid = ($urandom_range(0, 99) < 55);
            bus.cmd_data  = 8'($urandom);
            bus.cmd_sel   = 3'($urandom);
            bus.res_ready = ($urandom_range(0, 99) < 50);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check("rnd_drained", 32'(exp_q.size()), 32'd0);
        tick();
        check("rnd_idle_level", 32'(bus.level), 32'd0);
        rnd_mon = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_barrel_feeder
